// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and constants for the register-file write arbiter
//
// Purpose: register address/data types, the slot payload struct and the
//          zero-register constant used by reg_write_arbiter.
// Ports:   none (package).
package reg_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    // Contents of one holding slot.
    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

endpackage

// File: rtl/reg_write_arbiter_rr.sv
// rtl/reg_write_arbiter_rr.sv - round-robin arbiter owning the last-grant pointer
//
// Purpose: picks the first asserted request at or after (last_grant+1) mod NUM_REQ.
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset; makes requester 0 highest priority
//   i_req        request vector (one bit per full slot)
//   i_advance    grant is being consumed this cycle; update the pointer
//   o_grant      one-hot grant (all zero when no request)
//   o_grant_idx  index of the granted requester
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic [IDX_W-1:0] r_last;
    logic             w_found;

    // Walk the requesters starting just after the last winner; the index
    // wraps explicitly so NUM_REQ need not be a power of two.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] sel;
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_last) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (!w_found && i_req[sel]) begin
                w_found      = 1'b1;
                o_grant[sel] = 1'b1;
                o_grant_idx  = sel;
            end
        end
    end

    // Pointer parked on the last requester so requester 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= IDX_W'(NUM_REQ - 1);
        end else if (i_advance && w_found) begin
            r_last <= o_grant_idx;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - shares the register-file write port between NUM_REQ writeback sources
//
// Purpose: one holding slot per source with valid/ready, round-robin issue of
//          one held write per cycle, writes to register 0 absorbed.
// Ports:
//   i_clk, i_rst        clock / synchronous active-high reset
//   i_req_valid         per-requester write request
//   o_req_ready         per-requester slot can accept this cycle
//   i_req_addr          packed destination registers, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   i_req_data          packed write data, same packing
//   o_wr_addr/o_wr_data/o_wr_enable  to the register file write port
//   o_grant_id          requester whose write is on o_wr_* this cycle
//   o_busy              any slot full or write enable high
//   o_conflict_count    saturating count of cycles with two or more slots full
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int DATA_WIDTH = 64,
    parameter  int ADDR_WIDTH = 5,
    parameter  int CNT_WIDTH  = 16,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [ADDR_WIDTH-1:0]         o_wr_addr,
    output logic [DATA_WIDTH-1:0]         o_wr_data,
    output logic                          o_wr_enable,
    output logic [IDX_W-1:0]              o_grant_id,
    output logic                          o_busy,
    output logic [CNT_WIDTH-1:0]          o_conflict_count
);

    wr_req_t                r_slot [NUM_REQ];
    logic [NUM_REQ-1:0]     r_slot_full;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic                   r_wr_enable;
    logic [IDX_W-1:0]       r_grant_id;
    logic [CNT_WIDTH-1:0]   r_conflict_count;

    logic [NUM_REQ-1:0]     w_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_any_full;
    logic [NUM_REQ-1:0]     w_accept;
    logic [2:0]             w_num_full;
    logic                   w_conflict;

    assign w_any_full = |r_slot_full;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (r_slot_full),
        .i_advance   (w_any_full),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // A slot being drained this cycle can be refilled at the same edge,
    // giving one write per cycle per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_req_ready[i] = !i_rst && (!r_slot_full[i] || w_grant[i]);
        end
    end

    assign w_accept = i_req_valid & o_req_ready;

    always_comb begin
        w_num_full = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_num_full = w_num_full + 3'(r_slot_full[i]);
        end
    end

    assign w_conflict = (w_num_full >= 3'd2);

    // Slots: an accepted write to register 0 is dropped here and simply lets
    // a granted slot empty as usual.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot_full <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i] && (i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_REG)) begin
                    r_slot_full[i]  <= 1'b1;
                    r_slot[i].addr  <= i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_slot[i].data  <= i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_grant[i]) begin
                    r_slot_full[i]  <= 1'b0;
                end
            end
        end
    end

    // Write-port registers; address/data/id hold when nothing is issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_enable <= 1'b0;
            r_grant_id  <= '0;
        end else if (w_any_full) begin
            r_wr_addr   <= r_slot[w_grant_idx].addr;
            r_wr_data   <= r_slot[w_grant_idx].data;
            r_wr_enable <= 1'b1;
            r_grant_id  <= w_grant_idx;
        end else begin
            r_wr_enable <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conflict_count <= '0;
        end else if (w_conflict && (r_conflict_count != {CNT_WIDTH{1'b1}})) begin
            r_conflict_count <= r_conflict_count + 1'b1;
        end
    end

    // Gating with reset kills a write already on the port so that the
    // register file never captures anything at an edge where reset is high.
    assign o_wr_enable      = r_wr_enable && !i_rst;
    assign o_wr_addr        = r_wr_addr;
    assign o_wr_data        = r_wr_data;
    assign o_grant_id       = r_grant_id;
    assign o_busy           = !i_rst && (w_any_full || r_wr_enable);
    assign o_conflict_count = r_conflict_count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter with a behavioural reference model
module tb_reg_write_arbiter;

    localparam int N  = 2;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int CW = 16;
    localparam int IW = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              wr_enable;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [CW-1:0]     conflict_count;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_addr       (req_addr),
        .i_req_data       (req_data),
        .o_wr_addr        (wr_addr),
        .o_wr_data        (wr_data),
        .o_wr_enable      (wr_enable),
        .o_grant_id       (grant_id),
        .o_busy           (busy),
        .o_conflict_count (conflict_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file stand-in fed by the write port.
    logic [63:0] tb_rf [32];
    logic        rf_clear = 1'b1;
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) tb_rf[i] <= '0;
        end else if (wr_enable === 1'b1) begin
            tb_rf[wr_addr] <= wr_data;
        end
    end

    // Reference model: slot occupancy, round-robin pointer, counter.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            gid;
    } exp_t;
    exp_t exp_q[$];

    bit            m_full [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    int            m_last   = N - 1;
    int            m_cnt    = 0;
    bit            m_issued = 1'b0;

    always @(negedge clk) begin
        int           g;
        int           nf;
        logic [N-1:0] er;
        logic         eb;
        g  = -1;
        nf = 0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (g < 0 && m_full[j]) g = j;
        end
        for (int i = 0; i < N; i++) nf += int'(m_full[i]);
        for (int i = 0; i < N; i++) er[i] = !rst && (!m_full[i] || g == i);
        eb = !rst && (nf > 0 || m_issued);
        check("req_ready", 64'(req_ready), 64'(er));
        check("busy", 64'(busy), 64'(eb));
        check("wr_enable", 64'(wr_enable), 64'(m_issued && !rst));
        check("conflict_count", 64'(conflict_count), 64'(m_cnt));
        if (rst) begin
            for (int i = 0; i < N; i++) m_full[i] = 1'b0;
            m_last   = N - 1;
            m_cnt    = 0;
            m_issued = 1'b0;
            exp_q.delete();
        end else begin
            if (nf >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
            m_issued = (g >= 0);
            if (g >= 0) begin
                exp_q.push_back('{addr: m_addr[g], data: m_data[g], gid: g});
                m_full[g] = 1'b0;
                m_last    = g;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && er[i] && req_addr[i*AW +: AW] != '0) begin
                    m_full[i] = 1'b1;
                    m_addr[i] = req_addr[i*AW +: AW];
                    m_data[i] = req_data[i*DW +: DW];
                end
            end
        end
    end

    // Monitor: every write on the port must match the oldest expected one.
    always @(negedge clk) begin
        if (wr_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", wr_data, e.data);
                check("grant_id", 64'(grant_id), 64'(e.gid));
            end
        end
    end

    logic [N-1:0] last_acc;

    task automatic step();
        logic [N-1:0] rdy;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        last_acc = req_valid & rdy & {N{!rst}};
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_addr  = {5'd7, 5'd9};
        req_data  = '0;
        last_acc  = '0;
        step();
        rf_clear  = 1'b0;
        step();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("ready_after_reset", 64'(req_ready), 64'h3);

        // single write
        set_req(0, 5'd5, 64'h0123456789ABCDEF);
        req_valid = 2'b01;
        step();
        req_valid = '0;
        repeat (2) step();
        check("rf5", tb_rf[5], 64'h0123456789ABCDEF);

        // contention
        set_req(0, 5'd10, 64'h1234123412341234);
        set_req(1, 5'd15, 64'hAAAA5555AAAA5555);
        req_valid = 2'b11;
        step();
        req_valid = '0;
        repeat (3) step();
        check("rf10", tb_rf[10], 64'h1234123412341234);
        check("rf15", tb_rf[15], 64'hAAAA5555AAAA5555);
        check("conflict_pair1", 64'(conflict_count), 64'd1);

        // both to register 20: requester 0 was granted last, so requester 1
        // goes first and requester 0's data is left in the register
        set_req(0, 5'd20, 64'h0000000000000A00);
        set_req(1, 5'd20, 64'h0000000000000B11);
        req_valid = 2'b11;
        step();
        req_valid = '0;
        repeat (3) step();
        check("rf20_later_wins", tb_rf[20], 64'h0000000000000A00);
        check("conflict_pair2", 64'(conflict_count), 64'd2);

        // zero register
        set_req(1, 5'd0, 64'h1111111111111111);
        req_valid = 2'b10;
        step();
        req_valid = '0;
        repeat (2) step();
        check("rf0", tb_rf[0], 64'h0);
        check("busy_zero_reg", 64'(busy), 64'h0);

        // back-to-back from one requester
        for (int a = 1; a <= 4; a++) begin
            set_req(0, 5'(a), 64'(a) * 64'h0101);
            req_valid = 2'b01;
            step();
            check("throughput_accept", 64'(last_acc), 64'h1);
        end
        req_valid = '0;
        repeat (3) step();
        check("rf4", tb_rf[4], 64'h0404);
        check("conflict_throughput", 64'(conflict_count), 64'd2);

        // reset with both slots full
        set_req(0, 5'd30, 64'hDEAD);
        set_req(1, 5'd31, 64'hBEEF);
        req_valid = 2'b11;
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        check("rf30_after_reset", tb_rf[30], 64'h0);
        check("rf31_after_reset", tb_rf[31], 64'h0);
        check("conflict_after_reset", 64'(conflict_count), 64'd0);

        // randomized traffic with held requests and occasional resets
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_acc[i] || rst) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            {$urandom, $urandom});
                end
            end
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst       = 1'b0;
        req_valid = '0;
        repeat (6) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
